// File: rtl/deg_pkg.sv
// Shared constants and state encoding for the degree-job scheduler.
package deg_pkg;

  localparam int unsigned COEF_W      = 16;
  localparam int unsigned NCOEF       = 9;
  localparam int unsigned DEG_W       = 4;
  localparam int unsigned TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLaunch = 2'd1,
    StWait   = 2'd2,
    StResp   = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: ptr names the requester that currently has priority.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant
);

  // One-hot grant, prioritised requester first.
  always_comb begin
    grant = 2'b00;
    if (!ptr) begin
      if (req[0]) begin
        grant = 2'b01;
      end else if (req[1]) begin
        grant = 2'b10;
      end
    end else begin
      if (req[1]) begin
        grant = 2'b10;
      end else if (req[0]) begin
        grant = 2'b01;
      end
    end
  end

endmodule

// File: rtl/deg_sched.sv
// Schedules degree jobs from two requesters onto a single external DEG unit.
module deg_sched import deg_pkg::*; #(
  parameter int unsigned M       = COEF_W * NCOEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             req0,
  input  logic             req1,
  input  logic [0:M-1]     poly0,
  input  logic [0:M-1]     poly1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             ack0,
  output logic             ack1,
  output logic [DEG_W-1:0] deg_res,
  output logic             deg_err,
  output logic             deg_start,
  output logic [0:M-1]     deg_poly,
  input  logic [DEG_W-1:0] deg_in,
  input  logic             deg_done,
  output logic             busy
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLast = TW'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             win_q, win_d;     // id of the requester owning the current job
  logic             ptr_q, ptr_d;     // requester with priority at the next arbitration
  logic [0:M-1]     job_q, job_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [DEG_W-1:0] res_q, res_d;
  logic             err_q, err_d;
  logic [1:0]       arb_grant;

  rr_arb2 u_arb (
    .req   ({req1, req0}),
    .ptr   (ptr_q),
    .grant (arb_grant)
  );

  // Next-state logic for the job FSM, timer and datapath registers.
  always_comb begin
    state_d = state_q;
    gnt_d   = 2'b00;
    win_d   = win_q;
    ptr_d   = ptr_q;
    job_d   = job_q;
    timer_d = timer_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (|arb_grant) begin
          gnt_d   = arb_grant;
          win_d   = arb_grant[1];
          job_d   = arb_grant[1] ? poly1 : poly0;
          state_d = StLaunch;
        end
      end
      StLaunch: begin
        timer_d = '0;
        state_d = StWait;
      end
      StWait: begin
        // A done on the expiry cycle still counts as a valid result.
        if (deg_done) begin
          res_d   = deg_in;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (timer_q == TLast) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StResp: begin
        ptr_d   = ~win_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= StIdle;
      gnt_q   <= 2'b00;
      win_q   <= 1'b0;
      ptr_q   <= 1'b0;
      job_q   <= '0;
      timer_q <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      job_q   <= job_d;
      timer_q <= timer_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  // Outputs are registers or pure state decodes.
  always_comb begin
    gnt0      = gnt_q[0];
    gnt1      = gnt_q[1];
    deg_start = (state_q == StLaunch);
    ack0      = (state_q == StResp) && !win_q;
    ack1      = (state_q == StResp) && win_q;
    busy      = (state_q != StIdle);
    deg_poly  = job_q;
    deg_res   = res_q;
    deg_err   = err_q;
  end

endmodule

// File: tb/tb_deg_sched.sv
// Self-checking bench for deg_sched with a stub DEG unit and a job-level reference model.
module tb_deg_sched;

  localparam int M  = 144;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst_b = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [0:M-1] poly0 = '0, poly1 = '0;
  logic         gnt0, gnt1, ack0, ack1;
  logic [3:0]   deg_res;
  logic         deg_err, deg_start, busy;
  logic [0:M-1] deg_poly;
  logic [3:0]   deg_in = '0;
  logic         deg_done = 1'b0;

  int total = 0;
  int bad   = 0;

  // Reference model state: pending jobs, their polynomials, last served requester.
  bit           pend [2];
  logic [0:M-1] pm   [2];
  int           last_served;
  logic [3:0]   prev_res;
  logic         prev_err;

  deg_sched #(.M(M), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .req0      (req0),
    .req1      (req1),
    .poly0     (poly0),
    .poly1     (poly1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .ack0      (ack0),
    .ack1      (ack1),
    .deg_res   (deg_res),
    .deg_err   (deg_err),
    .deg_start (deg_start),
    .deg_poly  (deg_poly),
    .deg_in    (deg_in),
    .deg_done  (deg_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Degree = index of the highest nonzero 16-bit coefficient, 0 for the zero polynomial.
  function automatic int deg_of(input logic [0:M-1] p);
    int d = 0;
    for (int c = 0; c < 9; c++) begin
      logic [15:0] co;
      co = p[c*16 +: 16];
      if (co != 16'h0) d = c;
    end
    return d;
  endfunction

  function automatic logic [0:M-1] rand_poly();
    logic [0:M-1] p = '0;
    int t = $urandom_range(0, 9);
    for (int c = 0; c < 9; c++) begin
      if (c < t) p[c*16 +: 16] = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'h0;
      else if (c == t) p[c*16 +: 16] = 16'($urandom_range(1, 65535));
    end
    return p;
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic post(input int who, input logic [0:M-1] p);
    pm[who]   = p;
    pend[who] = 1'b1;
    if (who == 0) begin poly0 = p; req0 = 1'b1; end
    else begin poly1 = p; req1 = 1'b1; end
  endtask

  task automatic model_reset();
    last_served = 1;
    prev_res    = '0;
    prev_err    = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, {gnt1, gnt0}, 0);
    chk({tag, "_ack"}, {ack1, ack0}, 0);
    chk({tag, "_start"}, deg_start, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_res"}, deg_res, 0);
    chk({tag, "_err"}, deg_err, 0);
    chk({tag, "_poly"}, deg_poly, 0);
  endtask

  // Serve one job; the stub DEG answers lat cycles after LAUNCH (0 = never).
  task automatic serve_one(input int lat);
    int           who, exp_ack, exp_deg;
    bit           exp_err;
    logic [0:M-1] jp;
    who     = (pend[0] && pend[1]) ? 1 - last_served : (pend[0] ? 0 : 1);
    jp      = pm[who];
    exp_deg = deg_of(jp);
    exp_err = !(lat >= 1 && lat <= TO);
    exp_ack = exp_err ? TO + 1 : lat + 1;
    @(negedge clk);
    deg_done = 1'b0;
    chk("gnt0", gnt0, who == 0);
    chk("gnt1", gnt1, who == 1);
    chk("start", deg_start, 1);
    chk("busy_launch", busy, 1);
    chk("poly", deg_poly, jp);
    chk("res_hold", deg_res, prev_res);
    chk("err_hold", deg_err, prev_err);
    // Polynomial is captured, so the requester may scribble on it.
    pm[who] = rand_poly();
    if (who == 0) poly0 = pm[0]; else poly1 = pm[1];
    for (int k = 1; k <= exp_ack + 1; k++) begin
      @(negedge clk);
      deg_done = (k == lat);
      deg_in   = (k == lat) ? 4'(deg_of(deg_poly)) : 4'($urandom);
      chk("gnt_pulse", {gnt1, gnt0}, 0);
      chk("start_pulse", deg_start, 0);
      chk("ack0", ack0, (k == exp_ack) && (who == 0));
      chk("ack1", ack1, (k == exp_ack) && (who == 1));
      if (k <= exp_ack) chk("poly_hold", deg_poly, jp);
      if (k < exp_ack) begin
        chk("busy_wait", busy, 1);
      end else if (k == exp_ack) begin
        chk("res", deg_res, exp_err ? 0 : exp_deg);
        chk("err", deg_err, exp_err);
        chk("busy_resp", busy, 1);
        prev_res    = exp_err ? 4'd0 : 4'(exp_deg);
        prev_err    = exp_err;
        pend[who]   = 1'b0;
        last_served = who;
        if (who == 0) req0 = 1'b0; else req1 = 1'b0;
      end else begin
        chk("busy_idle", busy, 0);
        chk("res_after", deg_res, prev_res);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [0:M-1] p;
    int           pat;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    model_reset();

    // Reset state.
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_b = 1'b1;

    // Single job, coefficient 5 = 0x00A3.
    p = '0;
    p[80 +: 16] = 16'h00A3;
    post(0, p);
    serve_one(3);

    // Simultaneous requests after reset: requester 0 first.
    do_reset();
    p = '0;
    p[128 +: 16] = 16'h1234;
    post(0, p);
    p = '0;
    p[32 +: 16] = 16'h0001;
    p[0 +: 16]  = 16'hFFFF;
    post(1, p);
    serve_one(2);
    serve_one(5);

    // Zero polynomial, then another simultaneous pair that now favours requester 1.
    post(0, '0);
    serve_one(1);
    post(0, rand_poly());
    post(1, rand_poly());
    serve_one(4);
    serve_one(6);

    // Timeouts: done never, done in RESP, done in the following IDLE cycle.
    post(1, rand_poly());
    serve_one(0);
    post(0, rand_poly());
    serve_one(TO + 1);
    post(0, rand_poly());
    serve_one(TO + 2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_extra_ack", {ack1, ack0}, 0);
      chk("idle_busy", busy, 0);
    end

    // Done on the expiry cycle wins.
    post(1, rand_poly());
    serve_one(TO);

    // Reset in the middle of WAIT, then the still-held request reruns.
    p = '0;
    p[96 +: 16] = 16'h0F00;
    post(0, p);
    @(negedge clk);
    chk("mid_gnt0", gnt0, 1);
    repeat (3) @(negedge clk);
    chk("mid_busy", busy, 1);
    #2;
    rst_b = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    @(negedge clk);
    rst_b = 1'b1;
    model_reset();
    serve_one(4);

    // Randomised traffic.
    for (int it = 0; it < 30; it++) begin
      pat = $urandom_range(0, 2);
      if (pat != 1) post(0, rand_poly());
      if (pat != 0) post(1, rand_poly());
      while (pend[0] || pend[1]) serve_one($urandom_range(0, TO + 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
